// File: rtl/bus_arbiter_rr.sv
// Round-robin bus arbiter/router: grants one pending source FIFO at a time and forwards its head packet
// to the destination FIFO(s) decoded from the header. Define ARB_BCAST_EN to enable broadcast decoding of BCAST_ID.
module bus_arbiter_rr #(
  parameter int          drvrs    = 4,
  parameter int          pckg_sz  = 16,
  parameter logic [7:0]  BCAST_ID = 8'hFF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [drvrs-1:0]           pndng,
  input  logic [drvrs*pckg_sz-1:0]   D_pop,
  output logic [drvrs-1:0]           pop,
  input  logic [drvrs-1:0]           full,
  output logic [drvrs-1:0]           push,
  output logic [pckg_sz-1:0]         D_push,
  output logic [$clog2(drvrs)-1:0]   grant_id,
  output logic                       busy,
  output logic [7:0]                 drop_cnt
);
  localparam int IW = $clog2(drvrs);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t             state;
  logic [IW-1:0]      last;
  logic [drvrs-1:0]   mask;

  logic               found;
  logic [IW-1:0]      win;
  logic [pckg_sz-1:0] win_pkt;
  logic [7:0]         id;
  logic [drvrs-1:0]   mask_n;
  logic               blocked;
  logic               go;

  // Search starts one past the last winner and wraps, so every source gets a turn.
  always_comb begin
    found   = 1'b0;
    win     = '0;
    win_pkt = '0;
    for (int i = 1; i <= drvrs; i++) begin
      if (!found && pndng[(int'(last) + i) % drvrs]) begin
        found   = 1'b1;
        win     = IW'((int'(last) + i) % drvrs);
        win_pkt = D_pop[((int'(last) + i) % drvrs)*pckg_sz +: pckg_sz];
      end
    end
  end

  // An ID outside 0..drvrs-1 leaves the mask empty: the packet is popped and dropped.
  always_comb begin
    id     = win_pkt[pckg_sz-1 -: 8];
    mask_n = '0;
    for (int j = 0; j < drvrs; j++)
      mask_n[j] = (int'(id) == j);
`ifdef ARB_BCAST_EN
    if (id == BCAST_ID) begin
      mask_n      = '1;
      mask_n[win] = 1'b0;
    end
`endif
  end

  assign blocked = |(mask & full);
  assign go      = (state == GRANT) && !blocked;
  assign pop     = go ? (drvrs'(1) << grant_id) : '0;
  assign push    = go ? mask : '0;
  assign busy    = (state == GRANT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      last     <= IW'(drvrs-1);
      grant_id <= '0;
      D_push   <= '0;
      mask     <= '0;
      drop_cnt <= '0;
    end else begin
      case (state)
        IDLE: if (found) begin
          grant_id <= win;
          last     <= win;
          D_push   <= win_pkt;
          mask     <= mask_n;
          state    <= GRANT;
        end
        GRANT: if (!blocked) begin
          state <= IDLE;
          if (mask == '0 && drop_cnt != 8'hFF)
            drop_cnt <= drop_cnt + 8'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Scoreboard bench for bus_arbiter_rr: source FIFOs are modelled as queues, and each expected
// push/pop/data/grant tuple is queued when a packet is loaded and compared when the DUT pops it.
module tb_bus_arbiter_rr;
  localparam int N = 4;
  localparam int W = 16;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [N-1:0]     pndng = '0;
  logic [N*W-1:0]   D_pop = '0;
  logic [N-1:0]     pop;
  logic [N-1:0]     full = '0;
  logic [N-1:0]     push;
  logic [W-1:0]     D_push;
  logic [1:0]       grant_id;
  logic             busy;
  logic [7:0]       drop_cnt;

  bus_arbiter_rr #(.drvrs(N), .pckg_sz(W), .BCAST_ID(8'hFF)) dut (
    .clk(clk), .reset(reset), .pndng(pndng), .D_pop(D_pop), .pop(pop),
    .full(full), .push(push), .D_push(D_push), .grant_id(grant_id),
    .busy(busy), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0] push;
    logic [N-1:0] pop;
    logic [W-1:0] data;
    logic [1:0]   gid;
  } exp_t;

  exp_t        sb[$];
  logic [W-1:0] srcq[N][$];
  exp_t        mon_e;
  int          n_chk = 0;
  int          n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic refresh();
    for (int i = 0; i < N; i++) begin
      pndng[i]       = (srcq[i].size() > 0);
      D_pop[i*W +: W] = (srcq[i].size() > 0) ? srcq[i][0] : '0;
    end
  endtask

  task automatic load(input int s, input logic [W-1:0] pkt, input logic [N-1:0] exp_push, input bit expect_it);
    exp_t e;
    srcq[s].push_back(pkt);
    if (expect_it) begin
      e.push = exp_push;
      e.pop  = N'(1 << s);
      e.data = pkt;
      e.gid  = 2'(s);
      sb.push_back(e);
    end
    refresh();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    full  = '0;
    sb.delete();
    for (int i = 0; i < N; i++) srcq[i].delete();
    refresh();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic drain(input string tag, input int budget);
    for (int c = 0; c < budget && sb.size() > 0; c++) @(posedge clk);
    #1;
    chk(tag, sb.size(), 0);
  endtask

  // Monitor: any strobe must match the oldest expectation; a pop retires the source FIFO head.
  always @(negedge clk) begin
    if (!reset && (pop != '0 || push != '0)) begin
      if (sb.size() == 0) begin
        chk("unexpected_strobe", {push, pop}, '0);
      end else begin
        mon_e = sb.pop_front();
        chk("push", push, mon_e.push);
        chk("pop", pop, mon_e.pop);
        chk("d_push", D_push, mon_e.data);
        chk("grant_id", grant_id, mon_e.gid);
      end
      for (int i = 0; i < N; i++)
        if (pop[i] && srcq[i].size() > 0) void'(srcq[i].pop_front());
      refresh();
    end
  end

  initial begin
    // Reset state
    #2;
    chk("rst_pop", pop, 0);
    chk("rst_push", push, 0);
    chk("rst_dpush", D_push, 0);
    chk("rst_gid", grant_id, 0);
    chk("rst_busy", busy, 0);
    chk("rst_drop", drop_cnt, 0);
    do_reset();

    // Single unicast to dest 2
    load(0, 16'h0203, 4'b0100, 1);
    drain("drain_single", 20);
    chk("single_drop", drop_cnt, 0);

    // All sources pending: grants rotate 0,1,2,3,0,1,2,3
    do_reset();
    for (int r = 0; r < 2; r++)
      for (int s = 0; s < N; s++)
        load(s, {8'h00, 4'(r), 4'(s)}, 4'b0001, 1);
    drain("drain_rr", 40);

    // Head-of-line stall on full[3] for five cycles
    do_reset();
    full = 4'b1000;
    load(1, 16'h0311, 4'b1000, 1);
    @(posedge clk);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("stall_busy", busy, 1);
      chk("stall_push", push, 0);
      chk("stall_pop", pop, 0);
      chk("stall_dpush", D_push, 16'h0311);
    end
    @(posedge clk);
    #1 full = '0;
    drain("drain_stall", 10);
    chk("stall_idle", busy, 0);

    // Broadcast ID from source 2
    do_reset();
`ifdef ARB_BCAST_EN
    load(2, 16'hFF55, 4'b1011, 1);
    drain("drain_bcast", 20);
    chk("bcast_drop", drop_cnt, 0);
`else
    load(2, 16'hFF55, 4'b0000, 1);
    drain("drain_bcast", 20);
    chk("bcast_drop", drop_cnt, 1);
`endif

    // 300 drops: counter saturates
    do_reset();
    for (int k = 0; k < 300; k++) load(0, 16'h0700, 4'b0000, 1);
    drain("drain_drop", 1000);
    chk("drop_sat", drop_cnt, 255);

    // Reset while stalled in GRANT
    do_reset();
    full = 4'b1000;
    load(1, 16'h0311, 4'b1000, 0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("mid_busy", busy, 0);
    chk("mid_pop", pop, 0);
    chk("mid_push", push, 0);
    chk("mid_dpush", D_push, 0);
    chk("mid_gid", grant_id, 0);
    chk("mid_kept", srcq[1].size(), 1);
    srcq[1].delete();
    full = '0;
    refresh();
    @(posedge clk);
    #1 reset = 1'b0;
    load(2, 16'h0042, 4'b0001, 1);
    drain("drain_after_rst", 20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
